// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues the start
// request, then shifts one byte + odd parity + stop on device clock edges and checks the ack.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       txStart,
    input  logic [7:0] txByte,
    input  logic       ps2ClkIn,
    input  logic       ps2DataIn,
    output logic       ps2ClkOe,
    output logic       ps2DataOe,
    output logic       busy,
    output logic       txDone,
    output logic       txError
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int FLT_W   = $clog2(FILTER_LEN + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [FLT_W-1:0] FLT_LAST = FLT_W'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        ST_IDLE, ST_INHIBIT, ST_REQ, ST_SEND, ST_WAIT_ACK, ST_WAIT_IDLE, ST_DONE, ST_ERROR
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [9:0]       frame_q, frame_d;
    logic [1:0]       clk_sync_q, data_sync_q;
    logic [FLT_W-1:0] filt_cnt_q, filt_cnt_d;
    logic             clk_filt_q, clk_filt_d;
    logic             fall_edge_q, fall_edge_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Clock-line glitch filter: the filtered level follows only after FILTER_LEN agreeing samples.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FLT_LAST) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FLT_W'(1);
            end
        end else begin
            filt_cnt_d = '0;
        end
        fall_edge_d = clk_filt_q & ~clk_filt_d;
    end

    // Transfer sequencer; one counter serves both the inhibit period and the device timeout.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_cnt_d = bit_cnt_q;
        frame_d   = frame_q;
        data_oe_d = data_oe_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                data_oe_d = 1'b0;
                cnt_d     = '0;
                if (txStart) begin
                    frame_d = {1'b1, odd_parity(txByte), txByte};
                    state_d = ST_INHIBIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                    state_d   = ST_REQ;
                end else begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    data_oe_d = 1'b0;
                end
            end
            ST_REQ: begin
                // Start bit stays driven until the device's first falling edge.
                data_oe_d = 1'b1;
                bit_cnt_d = 4'd0;
                cnt_d     = '0;
                state_d   = ST_SEND;
            end
            ST_SEND: begin
                if (fall_edge_q) begin
                    data_oe_d = ~frame_q[bit_cnt_q];
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    cnt_d     = '0;
                    if (bit_cnt_q == 4'd9) begin
                        state_d = ST_WAIT_ACK;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else if (cnt_q == TO_LAST) begin
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_ACK: begin
                data_oe_d = 1'b0;
                if (fall_edge_q) begin
                    cnt_d = '0;
                    if (data_sync_q[1]) begin
                        err_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        state_d = ST_WAIT_IDLE;
                    end
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (clk_filt_q && data_sync_q[1]) begin
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_ERROR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
            ST_ERROR: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                data_oe_d = 1'b0;
                state_d   = ST_IDLE;
            end
        endcase
        clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQ);
        busy_d   = (state_d != ST_IDLE);
    end

    // State, synchronizers and registered outputs; reset releases both lines on the next cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= 4'd0;
            frame_q     <= 10'd0;
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_cnt_q  <= '0;
            clk_filt_q  <= 1'b1;
            fall_edge_q <= 1'b0;
            clk_oe_q    <= 1'b0;
            data_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            frame_q     <= frame_d;
            clk_sync_q  <= {clk_sync_q[0], ps2ClkIn};
            data_sync_q <= {data_sync_q[0], ps2DataIn};
            filt_cnt_q  <= filt_cnt_d;
            clk_filt_q  <= clk_filt_d;
            fall_edge_q <= fall_edge_d;
            clk_oe_q    <= clk_oe_d;
            data_oe_q   <= data_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign ps2ClkOe  = clk_oe_q;
    assign ps2DataOe = data_oe_q;
    assign busy      = busy_q;
    assign txDone    = done_q;
    assign txError   = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-collector bus and a simple keyboard model.
module tb_ps2_host_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txByte = 8'h00;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2ClkIn, ps2DataIn;
    logic       ps2ClkOe, ps2DataOe, busy, txDone, txError;

    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;
    logic prev_done = 1'b0;
    logic busy_after_done = 1'b1;
    logic done_busy = 1'b0;

    assign ps2ClkIn  = ~(ps2ClkOe | dev_clk_low);
    assign ps2DataIn = ~(ps2DataOe | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(2000), .FILTER_LEN(4)) dut (
        .clk(clk), .reset(reset), .txStart(txStart), .txByte(txByte),
        .ps2ClkIn(ps2ClkIn), .ps2DataIn(ps2DataIn),
        .ps2ClkOe(ps2ClkOe), .ps2DataOe(ps2DataOe),
        .busy(busy), .txDone(txDone), .txError(txError)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (txDone) begin
            done_cnt  <= done_cnt + 1;
            done_busy <= busy;
        end
        if (txError) err_cnt <= err_cnt + 1;
        prev_done <= txDone;
        if (prev_done) busy_after_done <= busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic start_tx(input logic [7:0] b);
        @(negedge clk);
        txByte  = b;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 500) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    // mode 0: normal ack, 1: no ack, 2: glitch + stray txStart, 3: reset after 4th data bit
    task automatic dev_frame(input int mode, output logic [10:0] got);
        int n = 0;
        got = '0;
        while (ps2ClkOe && n < 200) begin
            @(negedge clk);
            n++;
        end
        repeat (15) @(negedge clk);
        got[0] = ps2DataIn;
        for (int b = 0; b < 10; b++) begin
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            got[b+1] = ps2DataIn;
            dev_clk_low = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (mode == 2 && b == 3 && c == 8) begin
                    dev_clk_low = 1'b1;
                    txByte      = 8'hAA;
                    txStart     = 1'b1;
                end
                if (mode == 2 && b == 3 && c == 10) begin
                    dev_clk_low = 1'b0;
                    txStart     = 1'b0;
                end
            end
            if (mode == 3 && b == 3) begin
                reset = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                check("abort_outputs", 32'({ps2ClkOe, ps2DataOe, busy, txDone, txError}), 32'd0);
                return;
            end
        end
        dev_data_low = (mode != 1);
        repeat (5) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (3) @(negedge clk);
        dev_data_low = 1'b0;
    endtask

    initial begin
        logic [10:0] got;
        int d0, e0, n, m;

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'({ps2ClkOe, ps2DataOe, busy, txDone, txError}), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // 0xED: inhibit length, request, frame, ack
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        check("busy_on_start", 32'(busy), 32'd1);
        n = 0;
        while (ps2ClkOe && !ps2DataOe && n < 100) begin
            n++;
            @(negedge clk);
        end
        check("inhibit_len", 32'(n), 32'd20);
        check("req_both_low", 32'({ps2ClkOe, ps2DataOe}), 32'd3);
        @(negedge clk);
        check("send_entry", 32'({ps2ClkOe, ps2DataOe}), 32'd1);
        dev_frame(0, got);
        check("frame_ED", 32'(got), 32'h7DA);
        wait_idle("ED");
        check("ED_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("ED_err_cnt", 32'(err_cnt - e0), 32'd0);
        check("busy_at_done", 32'(done_busy), 32'd1);
        check("busy_after_done", 32'(busy_after_done), 32'd0);

        // 0x07 then 0x00 back to back
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h07);
        dev_frame(0, got);
        check("frame_07", 32'(got), 32'h40E);
        wait_idle("07");
        start_tx(8'h00);
        dev_frame(0, got);
        check("frame_00", 32'(got), 32'h600);
        wait_idle("00");
        check("b2b_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("b2b_err_cnt", 32'(err_cnt - e0), 32'd0);

        // missing ack
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        dev_frame(1, got);
        check("frame_noack", 32'(got), 32'h7DA);
        wait_idle("noack");
        check("noack_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("noack_done_cnt", 32'(done_cnt - d0), 32'd0);
        check("noack_lines", 32'({ps2ClkOe, ps2DataOe}), 32'd0);

        // device never clocks
        d0 = done_cnt;
        start_tx(8'hED);
        n = 0;
        while (ps2ClkOe && n < 200) begin
            @(negedge clk);
            n++;
        end
        m = 0;
        while (!txError && m < 5000) begin
            @(negedge clk);
            m++;
        end
        n_cmp++;
        assert (m >= 1998 && m <= 2002) else begin
            n_err++;
            $error("FAIL timeout_window: observed=%0d expected=2000+-2", m);
        end
        check("timeout_lines", 32'({ps2ClkOe, ps2DataOe}), 32'd0);
        wait_idle("timeout");
        check("timeout_done_cnt", 32'(done_cnt - d0), 32'd0);

        // reset mid-frame, then a clean 0xF4
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'h00);
        dev_frame(3, got);
        repeat (50) @(negedge clk);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_pulses", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
        start_tx(8'hF4);
        dev_frame(0, got);
        check("frame_F4", 32'(got), 32'h5E8);
        wait_idle("F4");
        check("F4_done_cnt", 32'(done_cnt - d0), 32'd1);

        // stray txStart and clock glitch during a frame
        d0 = done_cnt; e0 = err_cnt;
        start_tx(8'hED);
        dev_frame(2, got);
        check("frame_glitch", 32'(got), 32'h7DA);
        wait_idle("glitch");
        repeat (30) @(negedge clk);
        check("no_queued_start", 32'(busy), 32'd0);
        check("glitch_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("glitch_err_cnt", 32'(err_cnt - e0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
